axis_delay_calibrator: RTL and testbench
========================================

# axis_delay_calibrator

Measures the round-trip latency of an external AXI-Stream path by sending a single probe beat and timing its return. Computes the compensation delay that pads that path up to a programmed target latency. Sits directly upstream of the adjustable AXIS delay line and drives its `delay_count` input, so the electronic path can be realigned with the photonic path after power-up or reconfiguration.

## Interface
- `DATA_WIDTH`, 256: probe and return beat width.
- `MAX_LATENCY`, 50: largest legal `delay_count`. Equals the buffer depth of the downstream delay line.
- `TIMEOUT_CYCLES`, 1000: wait limit for the probe return. Must be in 1..65535.
- `PROBE_PATTERN`, {8{32'hA5C3_0F1E}}: probe payload, `DATA_WIDTH` bits.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin calibration. Ignored unless the FSM is in IDLE.
- `target_latency` in 16: desired total latency in cycles. Sampled only when `start` is accepted.
- `m_axis_tdata` out DATA_WIDTH: probe beat toward the path under test.
- `m_axis_tvalid` out 1: probe valid. There is no tready.
- `m_axis_tlast` out 1: asserted together with `m_axis_tvalid`.
- `s_axis_tdata` in DATA_WIDTH: beat returning from the path.
- `s_axis_tvalid` in 1: return beat valid.
- `s_axis_tlast` in 1: ignored.
- `delay_count` out 16: compensation value for the delay line.
- `delay_valid` out 1: `delay_count` holds a result from a successful calibration.
- `measured_latency` out 16: last measured round trip, L.
- `busy` out 1: FSM is in SEND, WAIT or DONE.
- `timeout` out 1: sticky. The last calibration timed out.
- `clamped` out 1: sticky. The last result was saturated.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE
  - `start`=1: latch `target_latency`, clear `timeout`, `clamped` and `delay_valid`, go to SEND.
- SEND (one cycle)
  - `m_axis_tvalid`=1, `m_axis_tlast`=1, `m_axis_tdata`=`PROBE_PATTERN`.
  - Latency counter `cnt` (16-bit) is 0 in this cycle. Go to WAIT.
- WAIT
  - `cnt` increments every cycle, so it equals the number of cycles since SEND.
  - Match condition: `s_axis_tvalid`=1 and `s_axis_tdata`==`PROBE_PATTERN` over the full width. On a match, latch L=`cnt` and go to DONE.
  - Valid beats that do not match are ignored.
  - The match check takes priority. Only if there is no match and `cnt`==`TIMEOUT_CYCLES`: set `timeout`, go to IDLE, leave `delay_count`, `delay_valid`=0 and `measured_latency` unchanged.
- DONE (one cycle)
  - Compute diff = target − L as a 17-bit signed value.
  - diff < 1: `delay_count`=1, `clamped`=1.
  - diff > `MAX_LATENCY`: `delay_count`=`MAX_LATENCY`, `clamped`=1.
  - Otherwise: `delay_count`=diff.
  - Write `measured_latency`=L, set `delay_valid`=1, go to IDLE.
- Matching is not performed in SEND, so a zero-latency combinational loopback is never seen.
- `m_axis_tdata` is 0 and `m_axis_tvalid`/`m_axis_tlast` are 0 in every state except SEND.

## Timing
- Reset values:
  - state IDLE, `cnt`=0
  - `delay_count`=1 (never 0, so the downstream index is always legal)
  - `measured_latency`=0
  - `delay_valid`, `busy`, `timeout`, `clamped`, `m_axis_*` = 0
- Reset is asynchronous: any state, including mid-WAIT, returns to IDLE immediately and `m_axis_tvalid` drops without waiting for a clock edge.
- `start` sampled at edge E: SEND is the cycle following E, with `busy`=1 from that cycle.
- Return beat sampled in WAIT at edge M: the following cycle is DONE. Results and `delay_valid` are visible, and `busy`=0, in the cycle after DONE.
- Round trip through an N-register path gives L=N.
- Timeout: `timeout` is visible, and `busy`=0, in the cycle after the edge where `cnt`==`TIMEOUT_CYCLES` was sampled.
- `start` while `busy` has no effect. `start` held high restarts calibration on return to IDLE.

## Test plan
- Probe looped back through 1 register, target 20 → L=1, `delay_count`=19, `delay_valid`=1, `clamped`=0.
- 10-stage loopback, target 20, plus a non-matching valid beat injected at cnt=4 → the injected beat is ignored, L=10, `delay_count`=10.
- 30-stage loopback, target 20 → `delay_count`=1, `clamped`=1. Then 5-stage loopback, target 100 → `delay_count`=50, `clamped`=1.
- No return, `TIMEOUT_CYCLES`=64 → `timeout`=1 one cycle after cnt=64 is sampled, `delay_valid`=0, `delay_count` keeps its prior value.
- `rst` asserted mid-WAIT → all outputs return to reset values asynchronously. A subsequent `start` with 3-stage loopback and target 8 → `delay_count`=5.
- `start` pulsed during WAIT → no restart, and the original measurement completes unchanged.

Source files
------------

// File: rtl/axis_delay_calibrator_if.sv
// rtl/axis_delay_calibrator_if.sv - single-beat stream bundle for probe and return paths
interface axis_delay_calibrator_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast);
    modport slave  (input  tdata, input  tvalid, input  tlast);
endinterface

// File: rtl/axis_delay_calibrator.sv
// rtl/axis_delay_calibrator.sv - probe round-trip latency and derive delay-line compensation
module axis_delay_calibrator #(
    parameter int                    DATA_WIDTH     = 256,
    parameter int                    MAX_LATENCY    = 50,
    parameter int                    TIMEOUT_CYCLES = 1000,
    parameter logic [DATA_WIDTH-1:0] PROBE_PATTERN  = {8{32'hA5C3_0F1E}}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [15:0]                    target_latency,
    axis_delay_calibrator_if.master        m_axis,
    axis_delay_calibrator_if.slave         s_axis,
    output logic [15:0]                    delay_count,
    output logic                           delay_valid,
    output logic [15:0]                    measured_latency,
    output logic                           busy,
    output logic                           timeout,
    output logic                           clamped
);

    localparam logic [15:0]        TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic signed [16:0] MAX_DIFF      = 17'(MAX_LATENCY);
    localparam logic [15:0]        MAX_COUNT     = 16'(MAX_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] target_q, target_d;
    logic [15:0] lat_q, lat_d;
    logic [15:0] delay_count_q, delay_count_d;
    logic        delay_valid_q, delay_valid_d;
    logic [15:0] measured_q, measured_d;
    logic        timeout_q, timeout_d;
    logic        clamped_q, clamped_d;

    logic               match;
    logic               at_limit;
    logic signed [16:0] diff;
    logic               unused_tlast;

    // The return beat's tlast carries no information for a single-beat probe.
    assign unused_tlast = s_axis.tlast;

    assign match    = s_axis.tvalid && (s_axis.tdata == PROBE_PATTERN);
    assign at_limit = (cnt_q == TIMEOUT_LIMIT);
    assign diff     = $signed({1'b0, target_q}) - $signed({1'b0, lat_q});

    // State register; reset is asynchronous so the probe drops immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a match outranks the timeout on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SEND;
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (match) begin
                    state_d = S_DONE;
                end else if (at_limit) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state: the probe is only on the wire during SEND.
    always_comb begin
        m_axis.tvalid = (state_q == S_SEND);
        m_axis.tlast  = (state_q == S_SEND);
        m_axis.tdata  = (state_q == S_SEND) ? PROBE_PATTERN : '0;
        busy          = (state_q != S_IDLE);
    end

    // Datapath next values: counter, latched target/latency and result registers.
    always_comb begin
        cnt_d         = cnt_q;
        target_d      = target_q;
        lat_d         = lat_q;
        delay_count_d = delay_count_q;
        delay_valid_d = delay_valid_q;
        measured_d    = measured_q;
        timeout_d     = timeout_q;
        clamped_d     = clamped_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (start) begin
                    target_d      = target_latency;
                    timeout_d     = 1'b0;
                    clamped_d     = 1'b0;
                    delay_valid_d = 1'b0;
                end
            end
            S_SEND: begin
                // cnt is 0 during SEND, so it reads 1 in the first WAIT cycle.
                cnt_d = 16'd1;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (match) begin
                    lat_d = cnt_q;
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                // Saturate to 1..MAX_LATENCY so the delay line index stays legal.
                if (diff < 17'sd1) begin
                    delay_count_d = 16'd1;
                    clamped_d     = 1'b1;
                end else if (diff > MAX_DIFF) begin
                    delay_count_d = MAX_COUNT;
                    clamped_d     = 1'b1;
                end else begin
                    delay_count_d = diff[15:0];
                end
                measured_d    = lat_q;
                delay_valid_d = 1'b1;
            end
            default: cnt_d = 16'd0;
        endcase
    end

    // Datapath registers; delay_count resets to 1, never 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= 16'd0;
            target_q      <= 16'd0;
            lat_q         <= 16'd0;
            delay_count_q <= 16'd1;
            delay_valid_q <= 1'b0;
            measured_q    <= 16'd0;
            timeout_q     <= 1'b0;
            clamped_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            lat_q         <= lat_d;
            delay_count_q <= delay_count_d;
            delay_valid_q <= delay_valid_d;
            measured_q    <= measured_d;
            timeout_q     <= timeout_d;
            clamped_q     <= clamped_d;
        end
    end

    assign delay_count      = delay_count_q;
    assign delay_valid      = delay_valid_q;
    assign measured_latency = measured_q;
    assign timeout          = timeout_q;
    assign clamped          = clamped_q;

endmodule

// File: tb/tb_axis_delay_calibrator.sv
// tb/tb_axis_delay_calibrator.sv - self-checking bench for axis_delay_calibrator
module tb_axis_delay_calibrator;

    localparam int              DW   = 256;
    localparam int              MAXL = 50;
    localparam int              TMO  = 64;
    localparam logic [DW-1:0]   PAT  = {8{32'hA5C3_0F1E}};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] target_latency;
    logic [15:0] delay_count;
    logic        delay_valid;
    logic [15:0] measured_latency;
    logic        busy;
    logic        timeout;
    logic        clamped;

    axis_delay_calibrator_if #(.DATA_WIDTH(DW)) m_if ();
    axis_delay_calibrator_if #(.DATA_WIDTH(DW)) s_if ();

    axis_delay_calibrator #(
        .DATA_WIDTH     (DW),
        .MAX_LATENCY    (MAXL),
        .TIMEOUT_CYCLES (TMO),
        .PROBE_PATTERN  (PAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .target_latency   (target_latency),
        .m_axis           (m_if),
        .s_axis           (s_if),
        .delay_count      (delay_count),
        .delay_valid      (delay_valid),
        .measured_latency (measured_latency),
        .busy             (busy),
        .timeout          (timeout),
        .clamped          (clamped)
    );

    always #5 clk = ~clk;

    // Loopback path: a register chain with a selectable tap; stages=0 means no return.
    int            stages;
    logic          inj;
    logic [DW-1:0] pd [0:127];
    logic          pv [0:127];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) begin
                pd[i] <= '0;
                pv[i] <= 1'b0;
            end
        end else begin
            pd[0] <= m_if.tdata;
            pv[0] <= m_if.tvalid;
            for (int i = 1; i < 128; i++) begin
                pd[i] <= pd[i-1];
                pv[i] <= pv[i-1];
            end
        end
    end

    always_comb begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        if (inj) begin
            s_if.tdata  = ~PAT;
            s_if.tvalid = 1'b1;
        end else if (stages > 0) begin
            s_if.tdata  = pd[stages-1];
            s_if.tvalid = pv[stages-1];
        end
        s_if.tlast = s_if.tvalid;
    end

    int total;
    int bad;
    int exp_delay;
    int exp_meas;

    typedef struct {
        int n;
        int tgt;
        int e_delay;
        int e_valid;
        int e_meas;
        int e_clamp;
        int e_to;
        int e_cyc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: latency is the path depth; result is target-L saturated to 1..MAXL.
    task automatic model(input int n, input int tgt,
                         output int e_delay, output int e_valid, output int e_meas,
                         output int e_clamp, output int e_to, output int e_cyc);
        int d;
        if (n == 0 || n > TMO) begin
            e_delay = exp_delay;
            e_valid = 0;
            e_meas  = exp_meas;
            e_clamp = 0;
            e_to    = 1;
            e_cyc   = TMO + 1;
        end else begin
            d       = tgt - n;
            e_clamp = (d < 1 || d > MAXL) ? 1 : 0;
            e_delay = (d < 1) ? 1 : ((d > MAXL) ? MAXL : d);
            e_valid = 1;
            e_meas  = n;
            e_to    = 0;
            e_cyc   = n + 2;
        end
    endtask

    task automatic run_cal(input string tag, input int n, input int tgt, output int cyc);
        int done;
        stages = n;
        repeat (72) @(negedge clk);
        start          = 1'b1;
        target_latency = tgt[15:0];
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".send_tvalid"}, int'(m_if.tvalid), 1);
        chk({tag, ".send_tlast"}, int'(m_if.tlast), 1);
        chk({tag, ".send_tdata"}, int'(m_if.tdata == PAT), 1);
        cyc  = busy ? 1 : 0;
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy) begin
                cyc++;
            end else begin
                done = 1;
                break;
            end
        end
        chk({tag, ".wait_bound"}, done, 1);
        chk({tag, ".idle_tvalid"}, int'(m_if.tvalid), 0);
    endtask

    task automatic check_res(input string tag, input int e_delay, input int e_valid,
                             input int e_meas, input int e_clamp, input int e_to,
                             input int e_cyc, input int cyc);
        chk({tag, ".delay_count"}, int'(delay_count), e_delay);
        chk({tag, ".delay_valid"}, int'(delay_valid), e_valid);
        chk({tag, ".measured"}, int'(measured_latency), e_meas);
        chk({tag, ".clamped"}, int'(clamped), e_clamp);
        chk({tag, ".timeout"}, int'(timeout), e_to);
        chk({tag, ".busy_cycles"}, cyc, e_cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, done;
        int e_delay, e_valid, e_meas, e_clamp, e_to, e_cyc;
        int n, tgt;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        target_latency = 16'd0;
        stages = 0;
        inj    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst.delay_count", int'(delay_count), 1);
        chk("rst.delay_valid", int'(delay_valid), 0);
        chk("rst.measured", int'(measured_latency), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.timeout", int'(timeout), 0);
        chk("rst.clamped", int'(clamped), 0);
        chk("rst.tvalid", int'(m_if.tvalid), 0);
        chk("rst.tdata_zero", int'(m_if.tdata == '0), 1);
        rst = 1'b0;
        exp_delay = 1;
        exp_meas  = 0;

        //            n   tgt  delay valid meas clamp to  cyc
        vecs[0] = '{  1,  20,  19,   1,    1,   0,    0,  3  };
        vecs[1] = '{ 30,  20,   1,   1,   30,   1,    0, 32  };
        vecs[2] = '{  5, 100,  50,   1,    5,   1,    0,  7  };
        vecs[3] = '{  0,  20,  50,   0,    5,   0,    1, 65  };
        vecs[4] = '{ 64, 100,  36,   1,   64,   0,    0, 66  };
        vecs[5] = '{ 65, 100,  36,   0,   64,   0,    1, 65  };
        vecs[6] = '{ 20,  20,   1,   1,   20,   1,    0, 22  };
        vecs[7] = '{ 20,  21,   1,   1,   20,   0,    0, 22  };
        vecs[8] = '{ 20,  70,  50,   1,   20,   0,    0, 22  };
        vecs[9] = '{ 20,  71,  50,   1,   20,   1,    0, 22  };

        for (int v = 0; v < 10; v++) begin
            run_cal($sformatf("vec%0d", v), vecs[v].n, vecs[v].tgt, cyc);
            check_res($sformatf("vec%0d", v), vecs[v].e_delay, vecs[v].e_valid,
                      vecs[v].e_meas, vecs[v].e_clamp, vecs[v].e_to, vecs[v].e_cyc, cyc);
            exp_delay = vecs[v].e_delay;
            exp_meas  = vecs[v].e_meas;
        end

        // 10-stage path with a junk beat at cnt=4 and a stray start at cnt=6.
        stages = 10;
        repeat (72) @(negedge clk);
        start = 1'b1;
        target_latency = 16'd20;
        @(negedge clk);
        start = 1'b0;
        cyc  = busy ? 1 : 0;
        done = 0;
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            if (!busy) begin
                inj   = 1'b0;
                start = 1'b0;
                done  = 1;
                break;
            end
            cyc++;
            inj   = (k == 4);
            start = (k == 6);
            if (k == 6) target_latency = 16'd99;
        end
        chk("inj.wait_bound", done, 1);
        check_res("inj", 10, 1, 10, 0, 0, 12, cyc);
        repeat (2) @(negedge clk);
        chk("inj.no_restart", int'(busy), 0);
        exp_delay = 10;
        exp_meas  = 10;

        // Randomized paths and targets against the reference model.
        for (int r = 0; r < 20; r++) begin
            n   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 70));
            tgt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 130));
            model(n, tgt, e_delay, e_valid, e_meas, e_clamp, e_to, e_cyc);
            run_cal($sformatf("rnd%0d_n%0d_t%0d", r, n, tgt), n, tgt, cyc);
            check_res($sformatf("rnd%0d_n%0d_t%0d", r, n, tgt),
                      e_delay, e_valid, e_meas, e_clamp, e_to, e_cyc, cyc);
            exp_delay = e_delay;
            exp_meas  = e_meas;
        end

        // Asynchronous reset in the middle of WAIT after a good result.
        run_cal("pre_rst", 1, 20, cyc);
        check_res("pre_rst", 19, 1, 1, 0, 0, 3, cyc);
        stages = 10;
        repeat (72) @(negedge clk);
        start = 1'b1;
        target_latency = 16'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrst.busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("wrst.busy", int'(busy), 0);
        chk("wrst.delay_count", int'(delay_count), 1);
        chk("wrst.delay_valid", int'(delay_valid), 0);
        chk("wrst.measured", int'(measured_latency), 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset during SEND drops the probe without a clock edge.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("srst.tvalid_before", int'(m_if.tvalid), 1);
        #2 rst = 1'b1;
        #1;
        chk("srst.tvalid", int'(m_if.tvalid), 0);
        chk("srst.tlast", int'(m_if.tlast), 0);
        chk("srst.busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_delay = 1;
        exp_meas  = 0;

        run_cal("post_rst", 3, 8, cyc);
        check_res("post_rst", 5, 1, 3, 0, 0, 5, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
